// File: rtl/if_id_stage.sv
// Fetch-stage PC register and IF/ID pipeline register with hazard stall/flush handling.
// Define IF_ID_PERF_CNT_EN to build the saturating stall/flush performance counters.
module if_id_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013,
    parameter int          CNT_W     = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             PCWrite_i,
    input  logic             Stall_i,
    input  logic             Flush_i,
    input  logic [31:0]      branch_target_i,
    input  logic [31:0]      instr_i,
    output logic [31:0]      pc_o,
    output logic [31:0]      ifid_pc_o,
    output logic [31:0]      ifid_instr_o,
    output logic             ifid_valid_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t      state, state_next;
    logic [31:0] pc, pc_next;
    logic [31:0] ifid_pc, ifid_pc_next;
    logic [31:0] ifid_instr, ifid_instr_next;
    logic        ifid_valid, ifid_valid_next;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            ifid_pc    <= 32'h0000_0000;
            ifid_instr <= NOP_INSTR;
            ifid_valid <= 1'b0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            ifid_pc    <= ifid_pc_next;
            ifid_instr <= ifid_instr_next;
            ifid_valid <= ifid_valid_next;
        end
    end

    // Stall outranks flush: a stalled branch in ID is re-evaluated next cycle.
    always_comb begin
        state_next      = state;
        pc_next         = pc;
        ifid_pc_next    = ifid_pc;
        ifid_instr_next = ifid_instr;
        ifid_valid_next = ifid_valid;
        case (state)
            IDLE: begin
                if (start_i) state_next = RUN;
            end
            RUN: begin
                if (!start_i) state_next = IDLE;
                if (Stall_i) begin
                    if (PCWrite_i) pc_next = pc + 32'd4;
                end else if (Flush_i) begin
                    ifid_pc_next    = pc;
                    ifid_instr_next = NOP_INSTR;
                    ifid_valid_next = 1'b0;
                    if (PCWrite_i) pc_next = branch_target_i;
                end else begin
                    ifid_pc_next    = pc;
                    ifid_instr_next = instr_i;
                    ifid_valid_next = 1'b1;
                    if (PCWrite_i) pc_next = pc + 32'd4;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pc_o         = pc;
    assign ifid_pc_o    = ifid_pc;
    assign ifid_instr_o = ifid_instr;
    assign ifid_valid_o = ifid_valid;

`ifdef IF_ID_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt, flush_cnt;
    logic             stall_evt, flush_evt;

    assign stall_evt = (state == RUN) && Stall_i;
    assign flush_evt = (state == RUN) && !Stall_i && Flush_i;

    // Counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_evt && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
            if (flush_evt && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
        end
    end

    assign stall_cnt_o = stall_cnt;
    assign flush_cnt_o = flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_if_id_stage.sv
// Self-checking bench for if_id_stage: directed scenarios plus randomized traffic
// compared against a behavioural pipeline model (two instances: default and wrapping PC / 2-bit counters).
module tb_if_id_stage;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start, pcw, stall, flush;
    logic [31:0] target;
    logic [31:0] instr0, pc0, ipc0, iinstr0, sc0, fc0;
    logic        valid0;
    logic [31:0] instr1, pc1, ipc1, iinstr1;
    logic        valid1;
    logic [1:0]  sc1, fc1;

    int total = 0;
    int bad   = 0;

`ifdef IF_ID_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] RPC1 = 32'hFFFF_FFF8;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    assign instr0 = mem(pc0);
    assign instr1 = mem(pc1);

    if_id_stage dut0 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .Stall_i(stall),
        .Flush_i(flush), .branch_target_i(target), .instr_i(instr0), .pc_o(pc0),
        .ifid_pc_o(ipc0), .ifid_instr_o(iinstr0), .ifid_valid_o(valid0),
        .stall_cnt_o(sc0), .flush_cnt_o(fc0)
    );

    if_id_stage #(.RESET_PC(RPC1), .CNT_W(2)) dut1 (
        .clk_i(clk), .rst_i(rst), .start_i(start), .PCWrite_i(pcw), .Stall_i(stall),
        .Flush_i(flush), .branch_target_i(target), .instr_i(instr1), .pc_o(pc1),
        .ifid_pc_o(ipc1), .ifid_instr_o(iinstr1), .ifid_valid_o(valid1),
        .stall_cnt_o(sc1), .flush_cnt_o(fc1)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ipc;
        logic [31:0] instr;
        logic        valid;
        logic        run;
        logic [31:0] sc;
        logic [31:0] fc;
    } model_t;

    model_t m0, m1;

    function automatic model_t reset_model(input logic [31:0] rpc);
        model_t n;
        n.pc = rpc; n.ipc = 32'h0; n.instr = NOP; n.valid = 1'b0;
        n.run = 1'b0; n.sc = 32'h0; n.fc = 32'h0;
        return n;
    endfunction

    // One clock edge of the pipeline front end, using the inputs present at that edge.
    function automatic model_t step(input model_t m, input logic [31:0] rpc, input logic [31:0] cmax);
        model_t n = m;
        if (!rst) return reset_model(rpc);
        if (m.run) begin
            if (stall) begin
                n.sc = (m.sc == cmax) ? m.sc : m.sc + 1;
                if (pcw) n.pc = m.pc + 32'd4;
            end else begin
                n.ipc = m.pc;
                if (flush) begin
                    n.instr = NOP; n.valid = 1'b0;
                    n.fc = (m.fc == cmax) ? m.fc : m.fc + 1;
                    if (pcw) n.pc = target;
                end else begin
                    n.instr = mem(m.pc); n.valid = 1'b1;
                    if (pcw) n.pc = m.pc + 32'd4;
                end
            end
        end
        n.run = start;
        return n;
    endfunction

    function automatic logic [31:0] ecnt(input logic [31:0] c);
        return PERF ? c : 32'h0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        m0 = step(m0, 32'h0, 32'hFFFF_FFFF);
        m1 = step(m1, RPC1, 32'd3);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; start = 1'b0; pcw = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h80;
        cyc(); cyc();
        total += 6;
        if (pc0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_pc got=%h exp=%h", pc0, 32'h0); end
        if (iinstr0 !== NOP) begin bad++; $display("[TB] FAIL reset_instr got=%h exp=%h", iinstr0, NOP); end
        if (valid0 !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b exp=0", valid0); end
        if (ipc0 !== 32'h0) begin bad++; $display("[TB] FAIL reset_ifid_pc got=%h exp=0", ipc0); end
        if ({sc0, fc0} !== 64'h0) begin bad++; $display("[TB] FAIL reset_cnt got=%h/%h exp=0/0", sc0, fc0); end
        if (pc1 !== RPC1) begin bad++; $display("[TB] FAIL reset_pc1 got=%h exp=%h", pc1, RPC1); end
        rst = 1'b1; flush = 1'b1;
        cyc(); cyc(); cyc();
        flush = 1'b0;
        total += 3;
        if (pc0 !== 32'h0) begin bad++; $display("[TB] FAIL idle_pc got=%h exp=0", pc0); end
        if (iinstr0 !== NOP) begin bad++; $display("[TB] FAIL idle_instr got=%h exp=%h", iinstr0, NOP); end
        if (valid0 !== 1'b0) begin bad++; $display("[TB] FAIL idle_valid got=%b exp=0", valid0); end
    endtask

    task automatic test_fetch();
        start = 1'b1; pcw = 1'b1;
        cyc();
        total += 2;
        if (pc0 !== 32'h0) begin bad++; $display("[TB] FAIL start_pc got=%h exp=0", pc0); end
        if (valid0 !== 1'b0) begin bad++; $display("[TB] FAIL start_valid got=%b exp=0", valid0); end
        for (int k = 1; k <= 2; k++) begin
            cyc();
            total += 4;
            if (pc0 !== 32'(4 * k)) begin bad++; $display("[TB] FAIL fetch_pc got=%h exp=%h", pc0, 32'(4 * k)); end
            if (ipc0 !== 32'(4 * (k - 1))) begin bad++; $display("[TB] FAIL fetch_ifid_pc got=%h exp=%h", ipc0, 32'(4 * (k - 1))); end
            if (iinstr0 !== mem(32'(4 * (k - 1)))) begin bad++; $display("[TB] FAIL fetch_instr got=%h exp=%h", iinstr0, mem(32'(4 * (k - 1)))); end
            if (valid0 !== 1'b1) begin bad++; $display("[TB] FAIL fetch_valid got=%b exp=1", valid0); end
            if (k == 1 && pc1 !== 32'hFFFF_FFFC) begin bad++; $display("[TB] FAIL wrap_pc got=%h exp=fffffffc", pc1); end
            if (k == 2 && pc1 !== 32'h0) begin bad++; $display("[TB] FAIL wrap_pc got=%h exp=00000000", pc1); end
            total += 1;
        end
    endtask

    task automatic test_stall();
        pcw = 1'b0; stall = 1'b1;
        cyc();
        total += 4;
        if (pc0 !== 32'h8) begin bad++; $display("[TB] FAIL stall_pc got=%h exp=8", pc0); end
        if (ipc0 !== 32'h4) begin bad++; $display("[TB] FAIL stall_ifid_pc got=%h exp=4", ipc0); end
        if (iinstr0 !== mem(32'h4)) begin bad++; $display("[TB] FAIL stall_instr got=%h exp=%h", iinstr0, mem(32'h4)); end
        if (sc0 !== ecnt(32'd1)) begin bad++; $display("[TB] FAIL stall_cnt got=%0d exp=%0d", sc0, ecnt(32'd1)); end
        pcw = 1'b1; stall = 1'b0;
        cyc();
        total += 2;
        if (pc0 !== 32'hC) begin bad++; $display("[TB] FAIL resume_pc got=%h exp=c", pc0); end
        if (ipc0 !== 32'h8) begin bad++; $display("[TB] FAIL resume_ifid_pc got=%h exp=8", ipc0); end
    endtask

    task automatic test_flush();
        flush = 1'b1; target = 32'h40;
        cyc();
        total += 5;
        if (pc0 !== 32'h40) begin bad++; $display("[TB] FAIL flush_pc got=%h exp=40", pc0); end
        if (valid0 !== 1'b0) begin bad++; $display("[TB] FAIL flush_valid got=%b exp=0", valid0); end
        if (iinstr0 !== NOP) begin bad++; $display("[TB] FAIL flush_instr got=%h exp=%h", iinstr0, NOP); end
        if (ipc0 !== 32'hC) begin bad++; $display("[TB] FAIL flush_ifid_pc got=%h exp=c", ipc0); end
        if (fc0 !== ecnt(32'd1)) begin bad++; $display("[TB] FAIL flush_cnt got=%0d exp=%0d", fc0, ecnt(32'd1)); end
        flush = 1'b0;
        cyc();
        total += 3;
        if (ipc0 !== 32'h40) begin bad++; $display("[TB] FAIL target_ifid_pc got=%h exp=40", ipc0); end
        if (iinstr0 !== mem(32'h40)) begin bad++; $display("[TB] FAIL target_instr got=%h exp=%h", iinstr0, mem(32'h40)); end
        if (pc0 !== 32'h44) begin bad++; $display("[TB] FAIL target_pc got=%h exp=44", pc0); end
    endtask

    task automatic test_stall_flush();
        stall = 1'b1; flush = 1'b1; pcw = 1'b0; target = 32'h100;
        cyc();
        total += 4;
        if (pc0 !== 32'h44) begin bad++; $display("[TB] FAIL sf_pc got=%h exp=44", pc0); end
        if ({ipc0, valid0} !== {32'h40, 1'b1}) begin bad++; $display("[TB] FAIL sf_ifid got=%h/%b exp=40/1", ipc0, valid0); end
        if (fc0 !== ecnt(32'd1)) begin bad++; $display("[TB] FAIL sf_flush_cnt got=%0d exp=%0d", fc0, ecnt(32'd1)); end
        if (sc0 !== ecnt(32'd2)) begin bad++; $display("[TB] FAIL sf_stall_cnt got=%0d exp=%0d", sc0, ecnt(32'd2)); end
        stall = 1'b0; pcw = 1'b1;
        cyc();
        total += 3;
        if (pc0 !== 32'h100) begin bad++; $display("[TB] FAIL sf_taken_pc got=%h exp=100", pc0); end
        if ({ipc0, valid0} !== {32'h44, 1'b0}) begin bad++; $display("[TB] FAIL sf_taken_ifid got=%h/%b exp=44/0", ipc0, valid0); end
        if (fc0 !== ecnt(32'd2)) begin bad++; $display("[TB] FAIL sf_taken_cnt got=%0d exp=%0d", fc0, ecnt(32'd2)); end
        flush = 1'b0;
    endtask

    task automatic test_pause();
        start = 1'b0;
        cyc(); cyc(); cyc();
        total += 2;
        if (pc0 !== 32'h104) begin bad++; $display("[TB] FAIL pause_pc got=%h exp=104", pc0); end
        if ({ipc0, valid0} !== {32'h100, 1'b1}) begin bad++; $display("[TB] FAIL pause_ifid got=%h/%b exp=100/1", ipc0, valid0); end
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        cyc();
        stall = 1'b1; pcw = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        total += 4;
        if (pc0 !== 32'h0) begin bad++; $display("[TB] FAIL midrst_pc got=%h exp=0", pc0); end
        if ({ipc0, iinstr0, valid0} !== {32'h0, NOP, 1'b0}) begin bad++; $display("[TB] FAIL midrst_ifid got=%h/%h/%b exp=0/%h/0", ipc0, iinstr0, valid0, NOP); end
        if ({sc0, fc0} !== 64'h0) begin bad++; $display("[TB] FAIL midrst_cnt got=%h/%h exp=0/0", sc0, fc0); end
        if (pc1 !== RPC1) begin bad++; $display("[TB] FAIL midrst_pc1 got=%h exp=%h", pc1, RPC1); end
        rst = 1'b1; stall = 1'b0; pcw = 1'b1; start = 1'b0;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst    = ($urandom % 60) != 0;
            start  = ($urandom % 8) != 0;
            stall  = ($urandom % 4) == 0;
            pcw    = stall ? (($urandom % 4) == 0) : (($urandom % 6) != 0);
            flush  = ($urandom % 5) == 0;
            target = $urandom;
            cyc();
            total += 4;
            if ({pc0, ipc0, iinstr0, valid0} !== {m0.pc, m0.ipc, m0.instr, m0.valid}) begin
                bad++;
                $display("[TB] FAIL rand_dut0 got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                         pc0, ipc0, iinstr0, valid0, m0.pc, m0.ipc, m0.instr, m0.valid);
            end
            if ({sc0, fc0} !== {ecnt(m0.sc), ecnt(m0.fc)}) begin
                bad++;
                $display("[TB] FAIL rand_cnt0 got=%0d/%0d exp=%0d/%0d", sc0, fc0, ecnt(m0.sc), ecnt(m0.fc));
            end
            if ({pc1, ipc1, iinstr1, valid1} !== {m1.pc, m1.ipc, m1.instr, m1.valid}) begin
                bad++;
                $display("[TB] FAIL rand_dut1 got=%h/%h/%h/%b exp=%h/%h/%h/%b",
                         pc1, ipc1, iinstr1, valid1, m1.pc, m1.ipc, m1.instr, m1.valid);
            end
            if ({sc1, fc1} !== {2'(ecnt(m1.sc)), 2'(ecnt(m1.fc))}) begin
                bad++;
                $display("[TB] FAIL rand_cnt1 got=%0d/%0d exp=%0d/%0d", sc1, fc1, ecnt(m1.sc), ecnt(m1.fc));
            end
        end
    endtask

    initial begin
        m0 = reset_model(32'h0);
        m1 = reset_model(RPC1);
        test_reset();
        test_fetch();
        test_stall();
        test_flush();
        test_stall_flush();
        test_pause();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/if_id_stage.md
# if_id_stage

Fetch-stage PC register and IF/ID pipeline register for the 5-stage RISC-V core. It drives the instruction-memory address, latches the fetched instruction and its PC into the IF/ID register, and takes the hazard unit's PC-hold and stall controls and the ID stage's branch-flush request. It sits directly upstream of the load-use hazard detector: the detector reads the rs1/rs2 fields of `ifid_instr_o`, and its `PCWrite`/`Stall` outputs come back into this block.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000, PC value loaded at reset.
- `NOP_INSTR`, 32'h0000_0013, bubble encoding (`addi x0,x0,0`) placed in IF/ID on reset or flush.
- `CNT_W`, 32, width of the performance counters.

Ports:
- `clk_i` input 1: the single clock; all state updates on its rising edge.
- `rst_i` input 1: synchronous, active-low reset.
- `start_i` input 1: level run enable.
- `PCWrite_i` input 1: 1 allows the PC to update; 0 holds it (from the hazard detector).
- `Stall_i` input 1: 1 holds the IF/ID register (from the hazard detector).
- `Flush_i` input 1: branch taken in ID; the fetched instruction is on the wrong path.
- `branch_target_i` input 32: redirect address, valid when `Flush_i`=1.
- `instr_i` input 32: instruction memory read data for `pc_o`; combinational, valid in the same cycle.
- `pc_o` output 32: fetch address, registered.
- `ifid_pc_o` output 32: PC of the instruction held in IF/ID.
- `ifid_instr_o` output 32: instruction held in IF/ID.
- `ifid_valid_o` output 1: 1 = real instruction; 0 = bubble.
- `stall_cnt_o` output CNT_W: stall-cycle counter (see Configuration).
- `flush_cnt_o` output CNT_W: flush counter (see Configuration).

## Operation
- FSM states: IDLE (reset state), RUN.
  - IDLE -> RUN when `start_i`=1 at a clock edge.
  - RUN -> IDLE when `start_i`=0 at a clock edge.
  - Leaving RUN does not reset the PC or IF/ID.
- In IDLE, the PC, IF/ID and counters hold their values. All control inputs are ignored.
- In RUN, the following are evaluated at each edge, in priority order:
  1. `Stall_i`=1: IF/ID holds. `Flush_i` is ignored, because the branch in ID is stalled and is re-evaluated next cycle. The PC updates only if `PCWrite_i`=1 (normally 0 from the detector).
  2. `Flush_i`=1 (and `Stall_i`=0): IF/ID receives instr=`NOP_INSTR`, valid=0, pc=`pc_o`. If `PCWrite_i`=1, the PC takes `branch_target_i`; otherwise the PC holds and the flush is still applied to IF/ID.
  3. Otherwise: IF/ID receives instr=`instr_i`, pc=`pc_o`, valid=1. If `PCWrite_i`=1, the PC takes `pc_o`+4.
- PC arithmetic:
  - +4 is a 32-bit add that wraps modulo 2^32; 32'hFFFF_FFFC is followed by 32'h0000_0000.
  - `branch_target_i` is used unmodified; no alignment check.
- Reset (`rst_i`=0 at an edge) overrides everything, including mid-stall or mid-flush:
  - state=IDLE
  - `pc_o`=`RESET_PC`
  - `ifid_instr_o`=`NOP_INSTR`, `ifid_pc_o`=0, `ifid_valid_o`=0
  - counters=0

## Timing
- All outputs are registered; none has a combinational path from any input.
- Fetch latency: an address on `pc_o` in cycle N appears on `ifid_instr_o` in cycle N+1 (unless stalled or flushed).
- Redirect: a flush accepted at edge N gives `pc_o`=target after N. The target instruction reaches IF/ID after edge N+1. Exactly one bubble is inserted.
- Load-use stall (`PCWrite_i`=0, `Stall_i`=1 for one cycle): `pc_o` and IF/ID are unchanged for exactly one cycle, then resume.
- Back-to-back stalls hold for as many cycles as `Stall_i` stays 1; there is no internal limit.
- `start_i` rising at edge N: the first instruction is latched at edge N+1.

## Configuration
- Macro `IF_ID_PERF_CNT_EN`.
- Defined:
  - `stall_cnt_o` increments on every RUN edge with `Stall_i`=1.
  - `flush_cnt_o` increments on every accepted flush (RUN, `Flush_i`=1, `Stall_i`=0).
  - Both saturate at all-ones and clear on reset.
- Undefined: no counter registers are built; `stall_cnt_o` and `flush_cnt_o` are tied to 0.

## Test plan
- Reset: hold `rst_i`=0 for 2 cycles, then release with `start_i`=0 -> `pc_o`=0, `ifid_instr_o`=32'h13, `ifid_valid_o`=0, and all of these hold while in IDLE.
- Sequential fetch: `start_i`=1, memory returns word = address -> `pc_o` steps 0,4,8,12; `ifid_instr_o`/`ifid_pc_o` lag by one cycle; valid=1.
- Load-use stall: at `pc_o`=8, drive `PCWrite_i`=0 and `Stall_i`=1 for 1 cycle -> `pc_o` stays 8 and IF/ID holds the instruction at 4 for one extra cycle; `stall_cnt_o`=1 with the macro defined.
- Branch flush: at `pc_o`=12, drive `Flush_i`=1 with `branch_target_i`=32'h40 -> next `pc_o`=32'h40; IF/ID = bubble (valid=0); the following cycle IF/ID pc=32'h40; `flush_cnt_o`=1.
- Stall and flush together: `Stall_i`=1, `Flush_i`=1, `PCWrite_i`=0 -> PC and IF/ID unchanged, `flush_cnt_o` unchanged; next cycle `Flush_i` alone is taken.
- Wrap, pause and reset mid-operation:
  - `RESET_PC`=32'hFFFF_FFF8 -> `pc_o` goes FFF8, FFFC, 0000.
  - Drop `start_i` -> PC freezes.
  - Assert `rst_i`=0 during a stall -> `pc_o` returns to `RESET_PC` and IF/ID returns to the bubble.
